// File: rtl/ro_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency counter
// and the RO instance wrapper.
package ro_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_REPORT  = 2'd3
   } ro_state_e;

   localparam int unsigned RO_COUNT_WIDTH   = 16;
   localparam int unsigned RO_GATE_CYCLES   = 1000;
   localparam int unsigned RO_SETTLE_CYCLES = 16;
   localparam int unsigned RO_SYNC_STAGES   = 2;

   // Counter width able to hold 0..v-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned v);
      if (v <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(v);
      end
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous probe input followed by a one-flop
// delay; rise_o is high for one clock per synchronized rising edge.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   // synchronizer shift chain and edge-delay flop
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the RO, counts synchronized
// rising edges over a fixed gate window and flags counts outside the bounds.
module ro_freq_counter
   import ro_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH   = RO_COUNT_WIDTH,
   parameter int unsigned GATE_CYCLES   = RO_GATE_CYCLES,
   parameter int unsigned SETTLE_CYCLES = RO_SETTLE_CYCLES,
   parameter int unsigned SYNC_STAGES   = RO_SYNC_STAGES
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   cont_i,
   input  logic [COUNT_WIDTH-1:0] lo_bound_i,
   input  logic [COUNT_WIDTH-1:0] hi_bound_i,
   input  logic                   osc_in_i,
   output logic                   ro_en_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [COUNT_WIDTH-1:0] count_o,
   output logic                   fault_o
);

   localparam int unsigned GW = cnt_width(GATE_CYCLES);
   localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] EDGE_MAX = {COUNT_WIDTH{1'b1}};

   ro_state_e              state_q, state_d;
   logic [SW-1:0]          settle_q, settle_d;
   logic [GW-1:0]          gate_q, gate_d;
   logic [COUNT_WIDTH-1:0] edge_q, edge_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   fault_q, fault_d;
   logic                   done_q, done_d;
   logic                   ro_en_q, busy_q, active_d;
   logic                   rise_s;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .async_i(osc_in_i),
      .rise_o (rise_s)
   );

   // next-state and result logic
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      gate_d   = gate_q;
      edge_d   = edge_q;
      count_d  = count_q;
      fault_d  = fault_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_MEASURE;
               gate_d  = '0;
               edge_d  = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_MEASURE: begin
            // saturate rather than wrap so a runaway RO still reads as too fast
            if (rise_s && (edge_q != EDGE_MAX)) begin
               edge_d = edge_q + 1'b1;
            end else begin
               edge_d = edge_q;
            end
            if (gate_q == GATE_LAST) begin
               state_d = ST_REPORT;
            end else begin
               gate_d = gate_q + 1'b1;
            end
         end
         ST_REPORT: begin
            count_d = edge_q;
            fault_d = (edge_q < lo_bound_i) | (edge_q > hi_bound_i);
            done_d  = 1'b1;
            if (cont_i) begin
               state_d = ST_MEASURE;
               gate_d  = '0;
               edge_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      active_d = (state_d != ST_IDLE);
   end

   // state, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         gate_q   <= '0;
         edge_q   <= '0;
         count_q  <= '0;
         fault_q  <= 1'b0;
         done_q   <= 1'b0;
         ro_en_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         gate_q   <= gate_d;
         edge_q   <= edge_d;
         count_q  <= count_d;
         fault_q  <= fault_d;
         done_q   <= done_d;
         ro_en_q  <= active_d;
         busy_q   <= active_d;
      end
   end

   assign ro_en_o = ro_en_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign count_o = count_q;
   assign fault_o = fault_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: a 16-bit instance for the main
// measurements and a 4-bit instance for count saturation.
module tb_ro_freq_counter;

   typedef struct {
      int exp_cyc;
      int cmin;
      int cmax;
      bit flt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic [15:0] lo = 16'd0;
   logic [15:0] hi = 16'd0;
   logic        osc = 1'b0;
   logic        ro_en, busy, done, fault;
   logic [15:0] count;

   logic        start4 = 1'b0;
   logic [3:0]  lo4 = 4'd0;
   logic [3:0]  hi4 = 4'd0;
   logic        ro_en4, busy4, done4, fault4;
   logic [3:0]  count4;

   int   cyc = 0;
   int   nchecks = 0;
   int   nerr = 0;
   int   osc_half = 50;
   bit   osc_run = 1'b0;
   exp_t q[$];
   exp_t q4[$];
   exp_t me, me4;

   ro_freq_counter u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont),
      .lo_bound_i(lo), .hi_bound_i(hi), .osc_in_i(osc),
      .ro_en_o(ro_en), .busy_o(busy), .done_o(done),
      .count_o(count), .fault_o(fault)
   );

   ro_freq_counter #(.COUNT_WIDTH(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .cont_i(1'b0),
      .lo_bound_i(lo4), .hi_bound_i(hi4), .osc_in_i(osc),
      .ro_en_o(ro_en4), .busy_o(busy4), .done_o(done4),
      .count_o(count4), .fault_o(fault4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // asynchronous oscillator model, offset from the clock edges
   initial begin
      #3;
      forever begin
         if (osc_run) begin
            #(osc_half) osc = ~osc;
         end else begin
            osc = 1'b0;
            #1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_done(input string name, input exp_t e, input int c, input int cnt, input bit f);
      nchecks++;
      if (c != e.exp_cyc || cnt < e.cmin || cnt > e.cmax || f != e.flt) begin
         nerr++;
         $display("FAIL %s: cycle %0d count %0d fault %0d, expected cycle %0d count %0d..%0d fault %0d",
                  name, c, cnt, f, e.exp_cyc, e.cmin, e.cmax, e.flt);
      end
   endtask

   // scoreboard monitor for the 16-bit instance
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            nchecks++; nerr++;
            $display("FAIL done_in_reset: got 1, expected 0");
         end
      end else if (done) begin
         if (q.size() == 0) begin
            nchecks++; nerr++;
            $display("FAIL unexpected_done: cycle %0d count %0d, expected no done", cyc, count);
         end else begin
            me = q.pop_front();
            check_done("done16", me, cyc, int'(count), fault);
         end
      end
   end

   // scoreboard monitor for the 4-bit instance
   always @(negedge clk) begin
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            nchecks++; nerr++;
            $display("FAIL unexpected_done4: cycle %0d count %0d, expected no done", cyc, count4);
         end else begin
            me4 = q4.pop_front();
            check_done("done4", me4, cyc, int'(count4), fault4);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input int l, input int h, input int cmin, input int cmax, input bit f, input int n);
      exp_t e;
      lo = 16'(l);
      hi = 16'(h);
      for (int k = 0; k < n; k++) begin
         e.exp_cyc = cyc + 1018 + k * 1001;
         e.cmin = cmin;
         e.cmax = cmax;
         e.flt = f;
         q.push_back(e);
      end
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((q.size() != 0 || q4.size() != 0 || busy || busy4) && n < budget) begin
         tick(1);
         n++;
      end
      nchecks++;
      if (n >= budget) begin
         nerr++;
         $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
      end
   endtask

   initial begin
      exp_t e4;
      tick(3);
      check("rst_ro_en", int'(ro_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_count", int'(count), 0);
      check("rst_fault", int'(fault), 0);
      rst = 1'b0;
      tick(2);

      // 1: period 10 inside bounds
      osc_half = 50;
      osc_run = 1'b1;
      tick(20);
      issue(95, 105, 99, 101, 1'b0, 1);
      check("t1_ro_en_next", int'(ro_en), 1);
      wait_idle("t1", 1200);
      tick(2);
      check("t1_ro_en_idle", int'(ro_en), 0);

      // 2: period 10 below lo, then stuck RO with lo = 0
      issue(150, 200, 99, 101, 1'b1, 1);
      wait_idle("t2a", 1200);
      osc_run = 1'b0;
      tick(5);
      issue(0, 105, 0, 0, 1'b0, 1);
      wait_idle("t2b", 1200);

      // 3: continuous, period 8, cont dropped during the third window
      osc_half = 40;
      osc_run = 1'b1;
      tick(20);
      cont = 1'b1;
      issue(120, 130, 124, 126, 1'b0, 3);
      tick(2019 + 500 - 1);
      cont = 1'b0;
      wait_idle("t3", 1200);
      tick(1100);
      check("t3_busy_after", int'(busy), 0);

      // 4: 4-bit counter saturates at 15
      osc_half = 20;
      tick(20);
      lo4 = 4'd0;
      hi4 = 4'd14;
      e4.exp_cyc = cyc + 1018;
      e4.cmin = 15;
      e4.cmax = 15;
      e4.flt = 1'b1;
      q4.push_back(e4);
      start4 = 1'b1;
      tick(1);
      start4 = 1'b0;
      check("t4_ro_en4", int'(ro_en4), 1);
      wait_idle("t4", 1200);

      // 6: period stretches to 20 for 500 cycles mid-window
      osc_half = 50;
      tick(20);
      issue(95, 105, 73, 77, 1'b1, 1);
      tick(17 + 250 - 1);
      osc_half = 100;
      tick(500);
      osc_half = 50;
      wait_idle("t6", 1200);
      check("t6_fault_held", int'(fault), 1);

      // 5: reset during MEASURE, then start while busy
      lo = 16'd95;
      hi = 16'd105;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(500);
      rst = 1'b1;
      tick(1);
      check("t5_ro_en", int'(ro_en), 0);
      check("t5_busy", int'(busy), 0);
      check("t5_count", int'(count), 0);
      check("t5_fault", int'(fault), 0);
      check("t5_done", int'(done), 0);
      rst = 1'b0;
      tick(1200);
      issue(95, 105, 99, 101, 1'b0, 1);
      tick(100);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_idle("t5", 1200);
      tick(1100);
      check("t5_busy_after", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measurement end of the ring-oscillator interface. Drives the oscillator's enable, samples its output in the system clock domain and counts rising edges over a fixed gate window.
- Compares each count against programmable bounds and flags a frequency fault.
- Used in the fault-injection setup to detect laser-induced delay or glitch disturbance in the RO fabric.

Parameters:
- COUNT_WIDTH, 16, width of edge count and bound inputs
- GATE_CYCLES, 1000, clk cycles per measurement window (>= 2)
- SETTLE_CYCLES, 16, clk cycles after enable before the first window (>= SYNC_STAGES+1)
- SYNC_STAGES, 2, synchronizer flops on osc_in (>= 2)

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- cont  in  1  continuous mode; sampled at the end of each window
- lo_bound  in  COUNT_WIDTH  minimum acceptable count, inclusive
- hi_bound  in  COUNT_WIDTH  maximum acceptable count, inclusive
- osc_in  in  1  asynchronous ring oscillator output
- ro_en  out  1  oscillator enable
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, count/fault valid
- count  out  COUNT_WIDTH  last completed edge count, held until next done
- fault  out  1  last count outside [lo_bound, hi_bound], held with count

Behaviour:
- Reset: state=IDLE; ro_en=0, busy=0, done=0, count=0, fault=0; synchronizer, edge and gate counters cleared.
  - Reset mid-measurement aborts immediately. No done is issued and count/fault are cleared.
- Interface is single clock. osc_in passes through a SYNC_STAGES flop chain, then a 1-flop delay. An edge is registered when synced=1 and delayed=0.
  - Valid only for osc frequency < clk/2. The RO must be sized or divided accordingly; faster inputs alias and are not detected.
- FSM:
  - IDLE: ro_en=0. If start=1, go to SETTLE with the settle counter at 0.
  - SETTLE: ro_en=1. Edges are ignored. After SETTLE_CYCLES cycles, go to MEASURE with gate counter=0 and edge counter=0.
  - MEASURE: ro_en=1. The gate counter increments every cycle. The edge counter increments per detected edge and saturates at 2^COUNT_WIDTH-1 (no wrap). On the cycle the gate counter reaches GATE_CYCLES-1, go to REPORT.
    - Edges are counted on exactly GATE_CYCLES cycles, including the final cycle.
  - REPORT: one cycle.
    - count <= edge counter.
    - fault <= (edge counter < lo_bound) | (edge counter > hi_bound), with bounds sampled this cycle.
    - done pulses the following cycle, aligned with the updated count/fault.
    - If cont=1, go to MEASURE with counters cleared; ro_en stays 1 and no re-settle occurs.
    - Otherwise go to IDLE.
- Latency: first done occurs SETTLE_CYCLES + GATE_CYCLES + 2 cycles after start is sampled. In continuous mode, consecutive done pulses are GATE_CYCLES+1 cycles apart.
- start while busy is ignored, not queued. Dropping cont mid-window finishes the current window, then returns to IDLE.
- lo_bound > hi_bound: every result faults (no special case).
- osc_in stuck (RO dead or disabled): count=0; fault is set iff lo_bound > 0.
- busy is registered from state; done is never asserted in the same cycle as reset.

Decomposition:
- Shared package ro_pkg:
  - FSM state typedef (IDLE, SETTLE, MEASURE, REPORT)
  - Default width/cycle constants, shared with the RO instance wrapper.
- One natural sub-module, sync_edge_detect: synchronizer chain plus rising-edge pulse, parameterized by SYNC_STAGES. It is reusable for other asynchronous probe inputs.

Test Plan (bench defaults unless noted: COUNT_WIDTH=16, GATE_CYCLES=1000, SETTLE_CYCLES=16):
1. osc_in period 10 clk, lo=95, hi=105, start pulse -> ro_en high next cycle; a single done at start+1018; count in {99,100,101}; fault=0; then IDLE with ro_en=0.
2. Same osc_in, lo=150, hi=200 -> count about 100, fault=1. Then osc_in held 0 with lo=0 -> count=0, fault=0.
3. cont=1, osc_in period 8 clk -> done every 1001 cycles with count about 125 each. Clear cont mid-window -> exactly one further done, then busy=0.
4. COUNT_WIDTH=4, osc_in period 4 clk -> count saturates at 15, no wrap to a small value; fault=1 with hi=14.
5. rst asserted during MEASURE -> next cycle ro_en=0, busy=0, count=0, fault=0 and no done. A start pulse during busy produces no extra measurement.
6. Mid-window glitch: osc_in period changes from 10 to 20 clk for 500 cycles -> count about 75; fault=1 with lo=95, hi=105.
